// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed 7-segment scanner with blanking gaps and frame-aligned double buffer
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] disp_data,
  input  logic        disp_valid,
  output logic        disp_ready,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  sel,
  output logic [7:0]  segments,
  output logic [1:0]  digit_idx,
  output logic        frame_tick
);
  localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic {BLANK, SHOW} state_t;
  state_t state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [1:0]  ndig;
  logic [15:0] active, pend;
  logic        full;
  logic [3:0]  nib;
  logic [7:0]  hex, shown;
  assign disp_ready = ~full;
  always_comb begin
    nstate     = state;
    ncnt       = cnt + 1'b1;
    ndig       = digit_idx;
    frame_tick = 1'b0;
    if (!en) begin
      nstate = BLANK;
      ncnt   = '0;
      ndig   = '0;
    end else if (state == BLANK && cnt == CW'(BLANK_CYC - 1)) begin
      nstate = SHOW;
      ncnt   = '0;
    end else if (state == SHOW && cnt == CW'(SCAN_DIV - 1)) begin
      nstate     = BLANK;
      ncnt       = '0;
      ndig       = digit_idx + 2'd1;
      frame_tick = (digit_idx == 2'd3);
    end
  end
  // segments are registered, so decode the digit that will be showing after this edge
  assign nib   = active[{ndig, 2'b00} +: 4];
  assign shown = blank_mask[ndig] ? 8'hFF : {hex[7:1], hex[0] & ~dp_mask[ndig]};
  always_comb begin
    case (nib)
      4'h0: hex = 8'h03;
      4'h1: hex = 8'h9F;
      4'h2: hex = 8'h25;
      4'h3: hex = 8'h0D;
      4'h4: hex = 8'h99;
      4'h5: hex = 8'h49;
      4'h6: hex = 8'h41;
      4'h7: hex = 8'h1F;
      4'h8: hex = 8'h01;
      4'h9: hex = 8'h09;
      4'hA: hex = 8'h11;
      4'hB: hex = 8'hC1;
      4'hC: hex = 8'h63;
      4'hD: hex = 8'h85;
      4'hE: hex = 8'h61;
      default: hex = 8'h71;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BLANK;
      cnt       <= '0;
      digit_idx <= '0;
      sel       <= 4'hF;
      segments  <= 8'hFF;
      active    <= '0;
      pend      <= '0;
      full      <= 1'b0;
    end else begin
      state     <= nstate;
      cnt       <= ncnt;
      digit_idx <= ndig;
      sel       <= (nstate == SHOW) ? ~(4'b0001 << ndig) : 4'hF;
      segments  <= (nstate == SHOW) ? shown : 8'hFF;
      if (full && (frame_tick || !en)) begin
        active <= pend;
        full   <= 1'b0;
      end else if (disp_valid && !full) begin
        pend <= disp_data;
        full <= 1'b1;
      end
    end
  end
endmodule
